// File: rtl/early_debounce_ctrl.sv
// early_debounce_ctrl: early-response switch debouncer.
// db follows the first detected edge of sw on the next clock. A lockout
// window of WAIT_TICKS sample ticks (TICK_M clocks each) then holds db.
// Any sw activity during the window is ignored.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   sw         in   raw switch level, already synchronous to clk
//   db         out  debounced level (registered)
//   busy       out  lockout window running (registered)
//   rise_tick  out  1-cycle pulse on db rise   (only with EARLY_DB_EDGE_EN)
//   fall_tick  out  1-cycle pulse on db fall   (only with EARLY_DB_EDGE_EN)
//
// Optional feature macro: EARLY_DB_EDGE_EN adds rise_tick / fall_tick.
module early_debounce_ctrl #(
    parameter int unsigned TICK_M     = 1_000_000,
    parameter int unsigned WAIT_TICKS = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db,
    output logic busy
`ifdef EARLY_DB_EDGE_EN
    ,
    output logic rise_tick,
    output logic fall_tick
`endif
);

    localparam int unsigned TW = ($clog2(TICK_M) > 1) ? $clog2(TICK_M) : 1;
    localparam int unsigned WW = ($clog2(WAIT_TICKS) > 1) ? $clog2(WAIT_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_M - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_TICKS - 1);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    state_t          r_state;
    logic [TW-1:0]   r_tick;
    logic [WW-1:0]   r_wait;

    state_t          w_state_nxt;
    logic [TW-1:0]   w_tick_nxt;
    logic [WW-1:0]   w_wait_nxt;
    logic            w_db_nxt;
    logic            w_busy_nxt;
    logic            w_rise_nxt;
    logic            w_fall_nxt;
    logic            w_tick_end;
    logic            w_win_end;
    logic            w_in_wait;

    assign w_tick_end = (r_tick == TICK_LAST);
    assign w_win_end  = w_tick_end && (r_wait == WAIT_LAST);
    assign w_in_wait  = (r_state == WAIT1) || (r_state == WAIT0);

    // Next state, counters and next output levels.
    // Counters are held at 0 outside the windows, so every entry starts clean.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = '0;
        w_wait_nxt  = '0;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        w_db_nxt    = 1'b0;
        w_busy_nxt  = 1'b0;

        case (r_state)
            ZERO: begin
                if (sw) begin
                    w_state_nxt = WAIT1;
                    w_rise_nxt  = 1'b1;
                end
            end
            WAIT1: begin
                if (w_win_end) begin
                    w_state_nxt = ONE;
                end
            end
            ONE: begin
                if (!sw) begin
                    w_state_nxt = WAIT0;
                    w_fall_nxt  = 1'b1;
                end
            end
            WAIT0: begin
                if (w_win_end) begin
                    w_state_nxt = ZERO;
                end
            end
            default: w_state_nxt = ZERO;
        endcase

        // Window timing: tick wraps every TICK_M clocks, wait counts wraps.
        if (w_in_wait && !w_win_end) begin
            w_tick_nxt = w_tick_end ? '0 : r_tick + TW'(1);
            w_wait_nxt = w_tick_end ? r_wait + WW'(1) : r_wait;
        end

        w_db_nxt   = (w_state_nxt == WAIT1) || (w_state_nxt == ONE);
        w_busy_nxt = (w_state_nxt == WAIT1) || (w_state_nxt == WAIT0);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ZERO;
            r_tick  <= '0;
            r_wait  <= '0;
            db      <= 1'b0;
            busy    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tick  <= w_tick_nxt;
            r_wait  <= w_wait_nxt;
            db      <= w_db_nxt;
            busy    <= w_busy_nxt;
        end
    end

`ifdef EARLY_DB_EDGE_EN
    // Edge pulses line up with the first cycle of the new db level.
    always_ff @(posedge clk) begin
        if (reset) begin
            rise_tick <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            rise_tick <= w_rise_nxt;
            fall_tick <= w_fall_nxt;
        end
    end
`else
    logic w_unused_edges;
    assign w_unused_edges = w_rise_nxt ^ w_fall_nxt;
`endif

endmodule

// File: tb/tb_early_debounce_ctrl.sv
// Directed bench for early_debounce_ctrl with TICK_M=4, WAIT_TICKS=3
// (12-cycle lockout windows). Each step drives sw/reset, pushes the
// expected post-edge outputs, then pops and compares after the edge.
module tb_early_debounce_ctrl;

    localparam int unsigned TM  = 4;
    localparam int unsigned WT  = 3;
    localparam int          WIN = TM * WT;

    typedef struct packed {
        logic db;
        logic busy;
        logic rise;
        logic fall;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic sw;
    logic db;
    logic busy;
`ifdef EARLY_DB_EDGE_EN
    logic rise_tick;
    logic fall_tick;
`endif

    int   n_vec = 0;
    int   n_bad = 0;
    logic prev_db = 1'b0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    early_debounce_ctrl #(.TICK_M(TM), .WAIT_TICKS(WT)) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw),
        .db    (db),
        .busy  (busy)
`ifdef EARLY_DB_EDGE_EN
        ,
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
`endif
    );

    // One clock: apply inputs, queue the expected result, compare after the edge.
    task automatic cyc(input logic s, input logic r, input logic edb,
                       input logic ebusy, input string tag);
        exp_t e;
        exp_t got;
        sw    = s;
        reset = r;
        e.db   = edb;
        e.busy = ebusy;
        e.rise = edb && !prev_db;
        e.fall = !edb && prev_db && !r;
        prev_db = edb;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        got = exp_q.pop_front();
        n_vec++;
        assert ({db, busy} === {got.db, got.busy})
        else begin
            n_bad++;
            $error("FAIL %s: observed db/busy=%b%b expected %b%b",
                   tag, db, busy, got.db, got.busy);
        end
`ifdef EARLY_DB_EDGE_EN
        n_vec++;
        assert ({rise_tick, fall_tick} === {got.rise, got.fall})
        else begin
            n_bad++;
            $error("FAIL %s_edge: observed rise/fall=%b%b expected %b%b",
                   tag, rise_tick, fall_tick, got.rise, got.fall);
        end
`endif
    endtask

    initial begin
        sw    = 1'b0;
        reset = 1'b1;
        #2;

        // Reset with sw low, then idle.
        cyc(0, 1, 0, 0, "rst0");
        cyc(0, 1, 0, 0, "rst1");
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, "idle");

        // Rising edge: db/busy up next clock, 12-cycle window, steady sw=1.
        cyc(1, 0, 1, 1, "rise_entry");
        for (int i = 1; i < WIN; i++) cyc(1, 0, 1, 1, "win1_steady");
        for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, "one_steady");

        // One-cycle drop: db falls, window holds, db returns after busy falls.
        cyc(0, 0, 0, 1, "drop_entry");
        for (int i = 1; i < WIN; i++) cyc(1, 0, 0, 1, "win0_hold");
        cyc(1, 0, 0, 0, "zero_exit");
        cyc(1, 0, 1, 1, "rise_again");

        // sw toggling inside WAIT1 is ignored; sw=0 at exit -> 1-cycle ONE.
        for (int i = 1; i < WIN; i++)
            cyc(logic'(i % 2), 0, 1, 1, "win1_toggle");
        cyc(0, 0, 1, 0, "one_single");
        cyc(0, 0, 0, 1, "fall_entry");
        for (int i = 1; i < WIN; i++)
            cyc(logic'(i % 2 == 0), 0, 0, 1, "win0_toggle");
        cyc(0, 0, 0, 0, "zero_settle");
        cyc(0, 0, 0, 0, "zero_idle");

        // Reset in the middle of a WAIT1 window with sw held high.
        cyc(1, 0, 1, 1, "rise_pre_rst");
        for (int i = 1; i < 5; i++) cyc(1, 0, 1, 1, "win1_pre_rst");
        cyc(1, 1, 0, 0, "rst_mid");
        cyc(1, 1, 0, 0, "rst_hold");
        cyc(1, 0, 1, 1, "rise_post_rst");
        for (int i = 1; i < WIN; i++) cyc(1, 0, 1, 1, "win1_post_rst");
        cyc(1, 0, 1, 0, "one_post_rst");
        cyc(1, 0, 1, 0, "one_hold");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
